// File: rtl/reg_file_pkg.sv
// Purpose: shared sizes and types for the 32x32 register file.
// Optional feature macro used by the top: REG_FILE_WRITE_BYPASS_EN.
// Ports: none (package).
package reg_file_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0]  word_t;

    // True when an active write targets the given read address (r0 never forwards)
    function automatic logic fwd_hit(logic en, reg_addr_t wa, reg_addr_t ra);
        return en && (wa != '0) && (wa == ra);
    endfunction

endpackage

// File: rtl/wr_decoder_5x32.sv
// Purpose: turn wr_en + wr_addr into one-hot per-row write enables.
// Row 0 is the hardwired zero register, so its enable is never raised.
// Ports:
//   wr_en_i   - write enable
//   wr_addr_i - destination register address
//   row_en_o  - one-hot row enables (bit 0 always 0), combinational
module wr_decoder_5x32
    import reg_file_pkg::*;
(
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    output logic [NUM_REGS-1:0] row_en_o
);

    // One-hot decode with the zero register masked out
    always_comb begin
        row_en_o = '0;
        if (wr_en_i) begin
            row_en_o[wr_addr_i] = 1'b1;
        end
        row_en_o[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file_32x32.sv
// Purpose: 32-entry x 32-bit register file, two combinational read ports,
// one synchronous write port, r0 hardwired to zero. Read data feeds the
// downstream operand-select mux (A -> in[0], B -> in[1]).
// Macro REG_FILE_WRITE_BYPASS_EN: when defined, a read that collides with an
// active write returns wr_data in the same cycle; otherwise it returns the old
// value until the next rising edge.
// Ports:
//   clk, rst_n             - clock, async active-low reset (clears all rows)
//   wr_en/wr_addr/wr_data  - write port, sampled on rising clk
//   rd_addr_a/rd_addr_b    - read addresses
//   rd_data_a/rd_data_b    - combinational read data
module reg_file_32x32
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b
);

    logic [NUM_REGS-1:0] row_en;
    word_t               regs_q [NUM_REGS];
    word_t               regs_d [NUM_REGS];

    wr_decoder_5x32 u_wr_dec (
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .row_en_o  (row_en)
    );

    // Next-state per row: load wr_data where the decoder enables it
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_d[i] = row_en[i] ? wr_data : regs_q[i];
        end
    end

    // Storage array; reset clears every row without a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // 32:1 word select per port; address 0 forced to zero
    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
`ifdef REG_FILE_WRITE_BYPASS_EN
        // Write-through forwarding, held off during reset
        if (rst_n && fwd_hit(wr_en, wr_addr, rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (rst_n && fwd_hit(wr_en, wr_addr, rd_addr_b)) begin
            rd_data_b = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Purpose: self-checking bench for reg_file_32x32 (directed table, reset and
// sweep sequences, randomized traffic against an array-based reference).
// Honours REG_FILE_WRITE_BYPASS_EN for the collision expectations.
module tb_reg_file_32x32;
    import reg_file_pkg::*;

`ifdef REG_FILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst_n;
    logic      wr_en;
    reg_addr_t wr_addr;
    word_t     wr_data;
    reg_addr_t rd_addr_a;
    reg_addr_t rd_addr_b;
    word_t     rd_data_a;
    word_t     rd_data_b;

    int tests = 0;
    int fails = 0;

    word_t model [NUM_REGS];

    typedef struct {
        logic      we;
        reg_addr_t wa;
        word_t     wd;
        reg_addr_t ra;
        reg_addr_t rb;
        word_t     ea;
        word_t     eb;
    } vec_t;

    vec_t tbl [9];

    reg_file_32x32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference read: what the specification says a port shows right now
    function automatic word_t ref_read(input reg_addr_t ra);
        if (rst_n !== 1'b1) return '0;
        if (ra == '0) return '0;
        if (BYP && wr_en && wr_addr == ra) return wr_data;
        return model[ra];
    endfunction

    // One rising edge, with the reference updated as the spec dictates
    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1 && wr_en && wr_addr != '0) model[wr_addr] = wr_data;
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input reg_addr_t wa, input word_t wd,
                         input reg_addr_t ra, input reg_addr_t rb);
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        clear_model();

        // Test 1: held in reset with random write traffic, everything reads 0
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wr_en   = 1'($urandom);
            wr_addr = reg_addr_t'($urandom);
            wr_data = word_t'($urandom);
            for (int a = 0; a < 32; a++) begin
                rd_addr_a = reg_addr_t'(a);
                rd_addr_b = reg_addr_t'(31 - a);
                #0.1;
                check($sformatf("rst_hold_a[%0d]", a), rd_data_a, 32'h0);
                check($sformatf("rst_hold_b[%0d]", 31 - a), rd_data_b, 32'h0);
            end
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0, '0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed table: pre-edge reads, writes land on the following edge
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0, 32'h0};
        tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
        tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0, 32'h0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        tbl[5] = '{1'b1, 5'd7,  32'h00000001, 5'd31, 5'd5,  32'h12345678, 32'hDEADBEEF};
        tbl[6] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,
                   BYP ? 32'hA5A5A5A5 : 32'h00000001, BYP ? 32'hA5A5A5A5 : 32'h00000001};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'hA5A5A5A5, 32'h0};
        tbl[8] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd7,  32'hDEADBEEF, 32'hA5A5A5A5};
        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb);
            #1;
            check($sformatf("tbl[%0d].a", i), rd_data_a, tbl[i].ea);
            check($sformatf("tbl[%0d].b", i), rd_data_b, tbl[i].eb);
            tick();
        end

        // Test 5: fill r1..r31 with their index, then async reset between edges
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, reg_addr_t'(i), word_t'(i), '0, '0);
            tick();
        end
        drive(1'b0, '0, '0, 5'd3, 5'd31);
        #1;
        check("fill_r3", rd_data_a, 32'd3);
        check("fill_r31", rd_data_b, 32'd31);
        #1 rst_n = 1'b0;
        drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd3, 5'd31);
        #0.5;
        check("async_rst_r3", rd_data_a, 32'h0);
        check("async_rst_r31", rd_data_b, 32'h0);
        for (int a = 0; a < 32; a++) begin
            rd_addr_a = reg_addr_t'(a);
            rd_addr_b = 5'd9;
            #1;
            check($sformatf("async_rst_sweep[%0d]", a), rd_data_a, 32'h0);
            check("async_rst_fwd_r9", rd_data_b, 32'h0);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 5'd9, 5'd3);
        #2 rst_n = 1'b1;
        clear_model();
        #1;
        check("dropped_write_r9", rd_data_a, 32'h0);
        check("post_rst_r3", rd_data_b, 32'h0);
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h00000055, 5'd1, 5'd2);
        tick();
        drive(1'b0, '0, '0, 5'd9, 5'd1);
        #1;
        check("first_write_r9", rd_data_a, 32'h00000055);
        check("post_rst_r1", rd_data_b, 32'h0);

        // Test 6: write ~addr everywhere, read back (a, 31-a) pairs
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, reg_addr_t'(a), ~word_t'(a), '0, '0);
            tick();
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, '0, '0, reg_addr_t'(a), reg_addr_t'(31 - a));
            #1;
            check($sformatf("sweep_a[%0d]", a), rd_data_a,
                  (a == 0) ? 32'h0 : ~word_t'(a));
            check($sformatf("sweep_b[%0d]", 31 - a), rd_data_b,
                  ((31 - a) == 0) ? 32'h0 : ~word_t'(31 - a));
        end
        @(negedge clk);

        // Randomized traffic against the reference array, collisions biased in
        for (int c = 0; c < 400; c++) begin
            wr_en     = ($urandom_range(3) != 0);
            wr_addr   = reg_addr_t'($urandom);
            wr_data   = word_t'($urandom);
            rd_addr_a = ($urandom_range(3) == 0) ? wr_addr : reg_addr_t'($urandom);
            rd_addr_b = ($urandom_range(7) == 0) ? 5'd0 : reg_addr_t'($urandom);
            #1;
            check($sformatf("rand[%0d].a@%0d", c, rd_addr_a), rd_data_a, ref_read(rd_addr_a));
            check($sformatf("rand[%0d].b@%0d", c, rd_addr_b), rd_data_b, ref_read(rd_addr_b));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
